// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: instruction classes, branch conditions,
// sequencer states and status bit positions.
package cpu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned COND_W  = 2;
    localparam int unsigned STATE_W = 3;

    localparam int unsigned STAT_Z = 0;
    localparam int unsigned STAT_C = 1;

    localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
    localparam logic [OP_W-1:0] OP_ALU    = 3'b001;
    localparam logic [OP_W-1:0] OP_ALU_NF = 3'b010;
    localparam logic [OP_W-1:0] OP_LDS    = 3'b011;
    localparam logic [OP_W-1:0] OP_JMP    = 3'b100;
    localparam logic [OP_W-1:0] OP_BRC    = 3'b101;
    localparam logic [OP_W-1:0] OP_HALT   = 3'b110;

    localparam logic [COND_W-1:0] COND_AL = 2'b00;
    localparam logic [COND_W-1:0] COND_Z  = 2'b01;
    localparam logic [COND_W-1:0] COND_C  = 2'b10;
    localparam logic [COND_W-1:0] COND_NZ = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a condition holds for the given
// Z/C status bits. Purely combinational.
module cond_eval
    import cpu_pkg::*;
#(
    parameter int unsigned NumStatusBits = 2
) (
    input  logic [COND_W-1:0]        cond,
    input  logic [NumStatusBits-1:0] status,
    output logic                     taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = status[STAT_Z];
            COND_C:  taken = status[STAT_C];
            COND_NZ: taken = ~status[STAT_Z];
        endcase
    end

endmodule

// File: rtl/stat_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer; strobes are combinational decodes
// of the state, the class/cond latched in DECODE, and the live inputs.
module stat_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned NumStatusBits = 2
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     run,
    input  logic                     mem_ready,
    input  logic [OP_W-1:0]          op_class,
    input  logic [COND_W-1:0]        cond,
    input  logic [NumStatusBits-1:0] status,
    input  logic                     alu_done,
    output logic                     mem_req,
    output logic                     ir_load,
    output logic                     pc_inc,
    output logic                     pc_load,
    output logic                     alu_start,
    output logic                     reg_wr_en,
    output logic                     stat_wr_en,
    output logic                     sel_stat_in_alu_decoder,
    output logic                     halted,
    output logic [STATE_W-1:0]       state_dbg
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     cls_q, cls_d;
    logic [COND_W-1:0]   cond_q, cond_d;
    logic                first_q, first_d;
    logic                brc_taken;

    cond_eval #(
        .NumStatusBits (NumStatusBits)
    ) u_cond_eval (
        .cond   (cond_q),
        .status (status),
        .taken  (brc_taken)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cls_q   <= OP_NOP;
            cond_q  <= COND_AL;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cond_q  <= cond_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        cls_d                   = cls_q;
        cond_d                  = cond_q;
        first_d                 = 1'b0;
        mem_req                 = 1'b0;
        ir_load                 = 1'b0;
        pc_inc                  = 1'b0;
        pc_load                 = 1'b0;
        alu_start               = 1'b0;
        reg_wr_en               = 1'b0;
        stat_wr_en              = 1'b0;
        sel_stat_in_alu_decoder = 1'b0;
        halted                  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d  = op_class;
                cond_d = cond;
                case (op_class)
                    OP_ALU, OP_ALU_NF: begin
                        state_d = ST_EXEC;
                        first_d = 1'b1;
                    end
                    OP_LDS, OP_JMP, OP_BRC: state_d = ST_WB;
                    OP_HALT:                state_d = ST_HALT;
                    // NOP and the illegal class both retire here
                    default:                state_d = run ? ST_FETCH : ST_IDLE;
                endcase
            end
            ST_EXEC: begin
                alu_start = first_q;
                if (alu_done) state_d = ST_WB;
            end
            ST_WB: begin
                case (cls_q)
                    OP_ALU: begin
                        reg_wr_en               = 1'b1;
                        stat_wr_en              = 1'b1;
                        sel_stat_in_alu_decoder = 1'b1;
                    end
                    OP_ALU_NF: reg_wr_en  = 1'b1;
                    OP_LDS:    stat_wr_en = 1'b1;
                    OP_JMP:    pc_load    = 1'b1;
                    OP_BRC:    pc_load    = brc_taken;
                    default:   ;
                endcase
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_dbg = STATE_W'(state_q);

endmodule

// File: doc/stat_seq_ctrl.md
Name: stat_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the 8-bit core. Runs the FETCH/DECODE/EXEC/WB cycle and drives the status register's write enable and ALU/decoder source select. Drives the PC, IR, ALU-start and register-file write strobes. Evaluates conditional branches against the current status bits.

Parameters:
NumStatusBits, 2, width of status vector; bit0 = Z (zero), bit1 = C (carry); condition logic requires 2

Ports:
clk  in  1  system clock, all state on rising edge
res_n  in  1  synchronous reset, active low
run  in  1  1 = keep issuing instructions; 0 = finish current instruction then idle
mem_ready  in  1  instruction memory data valid (handshake with mem_req)
op_class  in  3  decoder instruction class, valid in DECODE cycle only
cond  in  2  branch condition from decoder, valid in DECODE cycle only
status  in  NumStatusBits  current status register contents
alu_done  in  1  ALU result valid, single-cycle pulse or level
mem_req  out  1  instruction fetch request
ir_load  out  1  load instruction register
pc_inc  out  1  increment PC
pc_load  out  1  load PC with jump target
alu_start  out  1  one-cycle ALU start pulse
reg_wr_en  out  1  register-file write strobe
stat_wr_en  out  1  status register write enable
sel_stat_in_alu_decoder  out  1  status source: 1 = ALU, 0 = decoder
halted  out  1  core stopped by HALT
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: when res_n=0 at a clock edge, go to IDLE and clear the latched class/cond regs. All outputs are 0 in IDLE, so no strobe is asserted in the first cycle after reset. Reset aborts any state, including EXEC and HALT.
- Outputs are combinational decodes of state, latched class/cond and inputs. No output is registered beyond the state itself.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: mem_req=1 for the whole state.
  - Cycle with mem_ready=1: ir_load=1, pc_inc=1, next state DECODE.
  - mem_ready=0: stay in FETCH.
  - A fetch is never abandoned; run=0 here has no effect until WB.
- DECODE: one cycle. Latch op_class and cond into internal regs; op_class/cond are don't-care afterwards. Next state by class:
  - 000 NOP: FETCH if run=1, else IDLE.
  - 001 ALU and 010 ALU_NF: EXEC.
  - 011 LDS (decoder sets status), 100 JMP, 101 BRC: WB.
  - 110 HALT: HALT.
  - 111 illegal: treated as NOP.
- EXEC:
  - alu_start=1 only in the first EXEC cycle, using an internal first-cycle flag.
  - Stay in EXEC until alu_done=1, then WB.
  - alu_done=1 in the first EXEC cycle is legal: alu_start and the exit to WB happen in the same cycle.
- WB: exactly one cycle; strobes depend on the latched class:
  - ALU: reg_wr_en=1, stat_wr_en=1, sel=1.
  - ALU_NF: reg_wr_en=1 only.
  - LDS: stat_wr_en=1, sel=0.
  - JMP: pc_load=1.
  - BRC: pc_load = condition true.
  - Next state: FETCH if run=1, else IDLE.
- Branch conditions: 00 always; 01 Z=1; 10 C=1; 11 Z=0.
  - Evaluated on status during the BRC WB cycle.
  - The status register updates on the edge ending a WB, so a BRC directly after an ALU op always sees the new flags (at least 3 cycles apart).
- sel_stat_in_alu_decoder is 0 whenever stat_wr_en=0.
- stat_wr_en and reg_wr_en are asserted only in WB, at most one cycle per instruction.
- HALT: halted=1, all strobes 0. Only reset leaves HALT; run is ignored.
- Minimum instruction time with mem_ready tied high:
  - NOP: 2 cycles (FETCH, DECODE).
  - LDS/JMP/BRC: 3 cycles.
  - ALU with immediate alu_done: 4 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - op_class constants OP_NOP, OP_ALU, OP_ALU_NF, OP_LDS, OP_JMP, OP_BRC, OP_HALT.
  - cond constants COND_AL, COND_Z, COND_C, COND_NZ.
  - FSM state constants.
  - Status bit indices STAT_Z=0, STAT_C=1.
- One sub-module: cond_eval (combinational; inputs cond, status; output taken). It is reused later by the conditional-move logic.

Test Plan:
- Reset held 2 cycles while run=1, op_class=ALU -> state_dbg=0 and all strobes 0 during reset and the first cycle after; FETCH on the next cycle.
- run=1, mem_ready delayed 3 cycles, class ALU, alu_done 2 cycles after alu_start -> mem_req high 4 cycles; ir_load/pc_inc single pulse; alu_start single pulse; one WB cycle with reg_wr_en=1, stat_wr_en=1, sel=1.
- Class LDS -> WB with stat_wr_en=1, sel=0, reg_wr_en=0; class ALU_NF -> stat_wr_en never asserted.
- ALU op whose result gives status=2'b01, then BRC cond=01 -> pc_load=1 in BRC WB. Repeat with cond=11 -> pc_load=0. cond=10 with status=2'b10 -> pc_load=1.
- run dropped during EXEC -> WB completes with correct strobes, then IDLE (state 0). Re-raising run -> FETCH next cycle.
- Class HALT -> halted=1 and the state stays 5 for 20 cycles while run toggles. res_n=0 -> IDLE, halted=0. Also res_n pulse in EXEC -> no WB strobes ever appear.
